periph_arbiter: RTL
===================

Name: periph_arbiter

Overview:
Round-robin arbiter and sequencer that shares the single peripheral bus (periph_sel / periph_addr / bus_we / bus_oe / bus_data) between N_REQ requesters, for example the CPU core and a debug/DMA engine.
Each granted request becomes one fixed-timing bus transaction on a peripheral such as the GPIO block. Read data and a one-cycle acknowledge are returned to the winning requester.

Parameters:
N_REQ, 2, number of requesters (≥2); index 0 wins the first arbitration after reset.
DATA_N, from config header (8), bus data width.
PERIPH_N, from config header, peripheral register address width.

Ports:
clk  input  1  peripheral clock, rising edge
n_reset  input  1  asynchronous active-low reset
req  input  N_REQ  per-requester request; held high until matching ack
req_we  input  N_REQ  1 = write, 0 = read; stable while req high
req_addr  input  N_REQ x PERIPH_N  register address; stable while req high
req_wdata  input  N_REQ x DATA_N  write data; stable while req high
ack  output  N_REQ  one-cycle completion pulse, one-hot
rdata  output  DATA_N  read data, valid when ack pulses for a read
busy  output  1  transaction in progress (state != IDLE)
periph_sel  output  1  peripheral select
periph_addr  output  PERIPH_N  peripheral register address
bus_we  output  1  write strobe
bus_oe  output  1  read strobe (peripheral drives bus_data)
bus_data  inout  DATA_N  shared data bus; driven only during a write ACCESS

Behaviour:
- Clocking and reset: clk is the only clock; n_reset is asynchronous, active-low.
- Reset values:
  - ack = 0, rdata = 0, busy = 0, periph_sel = 0, periph_addr = 0, bus_we = 0, bus_oe = 0.
  - bus_data released (all z).
  - State = IDLE; last-grant pointer = N_REQ-1.
- Outputs: all bus outputs and ack are registered; there is no combinational path from req to the bus.
- FSM is IDLE -> ACCESS -> RESP -> IDLE. One transaction takes 3 cycles; back-to-back throughput is 1 per 3 cycles.
- IDLE:
  - If any req is high, pick the first requester with req high, scanning from pointer+1 upward with wrap-around modulo N_REQ.
  - Latch its index, we, addr and wdata; update the pointer to that index; go to ACCESS.
  - With no req, stay in IDLE.
- ACCESS (exactly 1 cycle):
  - periph_sel = 1 and periph_addr = latched addr.
  - Write: bus_we = 1, bus_oe = 0, bus_data driven with latched wdata. The peripheral commits at the end-of-cycle edge.
  - Read: bus_oe = 1, bus_we = 0, bus_data z. rdata captures bus_data at the end-of-cycle edge.
- RESP (exactly 1 cycle):
  - periph_sel, bus_we and bus_oe are all 0 and bus_data is z; this is the turnaround cycle.
  - ack[granted] = 1.
  - rdata is valid for a read, and holds its value until the next read completes; writes do not change rdata.
- Requester rules:
  - On seeing ack at the RESP->IDLE edge, a requester either drops req or presents a new request in the IDLE cycle.
  - Request fields are latched at grant, so a req dropped or changed after grant does not affect the transaction in flight, and ack is still pulsed.
- Fairness: a requester holding req continuously is granted within N_REQ transactions. Two requesters issuing continuously alternate strictly.
- Simultaneous requests in IDLE: only the winner is latched; losers stay pending with no ack.
- Bus contention: bus_data is never driven while bus_oe = 1. Exactly one of bus_we and bus_oe is high in ACCESS; both are 0 otherwise.
- Reset mid-transaction (any state): outputs go immediately to reset values and bus_data is released. No ack is produced for the aborted transaction; requesters re-issue.
- Illegal addresses are passed through unchanged; a read returns whatever the peripheral drives (0 for undefined GPIO offsets).

Test Plan:
- Single write then read: requester 0 writes 0xA5 to GPIO_OUT, then reads GPIO_OUT.
  -> periph_sel and bus_we high for exactly 1 cycle; ack[0] 2 cycles after the grant edge; read returns rdata = 0xA5; bus_data z in RESP.
- Contention: req[0] and req[1] rise in the same cycle, both writes (0x11 and 0x22 to GPIO_DIR), right after reset.
  -> requester 0 is served first, requester 1 three cycles later; final GPIO_DIR = 0x22; ack pulses one-hot.
- Fairness: both requesters hold req continuously for 6 transactions.
  -> grant order 0,1,0,1,0,1; busy stays high except one IDLE cycle between transactions.
- Loopback: GPIO_DIR = 0xFF, GPIO_OUT = 0x3C, then read GPIO_IN via requester 1.
  -> rdata = 0x3C with ack[1]; rdata unchanged by a subsequent write.
- Reset during ACCESS of a write: assert n_reset mid-cycle.
  -> all bus outputs 0 and bus_data z asynchronously; no ack; after release, requester 0 wins the first arbitration.
- Req withdrawn after grant: requester drops req in the ACCESS cycle.
  -> transaction still completes and ack still pulses; no second transaction is issued.

Source files
------------

// File: rtl/periph_arbiter.sv
// rtl/periph_arbiter.sv - round-robin arbiter and fixed-timing sequencer for the shared peripheral bus
module periph_arbiter #(
   parameter int N_REQ    = 2,
   parameter int DATA_N   = 8,
   parameter int PERIPH_N = 4
) (
   input  logic                               clk,
   input  logic                               n_reset,
   input  logic [N_REQ-1:0]                   req,
   input  logic [N_REQ-1:0]                   req_we,
   input  logic [N_REQ-1:0][PERIPH_N-1:0]     req_addr,
   input  logic [N_REQ-1:0][DATA_N-1:0]       req_wdata,
   output logic [N_REQ-1:0]                   ack,
   output logic [DATA_N-1:0]                  rdata,
   output logic                               busy,
   output logic                               periph_sel,
   output logic [PERIPH_N-1:0]                periph_addr,
   output logic                               bus_we,
   output logic                               bus_oe,
   inout  wire  [DATA_N-1:0]                  bus_data
);

   localparam int IDX_W = $clog2(N_REQ);

   typedef enum logic [1:0] {
      S_IDLE   = 2'd0,
      S_ACCESS = 2'd1,
      S_RESP   = 2'd2
   } state_t;

   state_t               r_state;
   state_t               w_state_nxt;
   logic [IDX_W-1:0]     r_ptr;
   logic [IDX_W-1:0]     w_pick;
   logic [IDX_W-1:0]     w_cidx;
   logic                 w_found;
   logic [PERIPH_N-1:0]  r_addr;
   logic [DATA_N-1:0]    r_wdata;
   logic [DATA_N-1:0]    r_rdata;
   logic                 r_sel;
   logic                 r_we;
   logic                 r_oe;
   logic [N_REQ-1:0]     r_ack;

   // Round-robin pick: first active request after the last winner, wrapping around
   always_comb begin
      w_found = 1'b0;
      w_pick  = '0;
      w_cidx  = '0;
      for (int k = 1; k <= N_REQ; k++) begin
         w_cidx = IDX_W'((int'(r_ptr) + k) % N_REQ);
         if (!w_found && req[w_cidx]) begin
            w_found = 1'b1;
            w_pick  = w_cidx;
         end
      end
   end

   // Next-state logic: IDLE waits for a request, ACCESS and RESP last one cycle each
   always_comb begin
      w_state_nxt = r_state;
      case (r_state)
         S_IDLE:   if (w_found) w_state_nxt = S_ACCESS;
         S_ACCESS: w_state_nxt = S_RESP;
         S_RESP:   w_state_nxt = S_IDLE;
         default:  w_state_nxt = S_IDLE;
      endcase
   end

   // State register
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) r_state <= S_IDLE;
      else          r_state <= w_state_nxt;
   end

   // Grant latch and registered bus/ack outputs; strobes are one-cycle pulses by default
   always_ff @(posedge clk or negedge n_reset) begin
      if (!n_reset) begin
         r_ptr   <= IDX_W'(N_REQ - 1);
         r_addr  <= '0;
         r_wdata <= '0;
         r_rdata <= '0;
         r_sel   <= 1'b0;
         r_we    <= 1'b0;
         r_oe    <= 1'b0;
         r_ack   <= '0;
      end else begin
         r_sel <= 1'b0;
         r_we  <= 1'b0;
         r_oe  <= 1'b0;
         r_ack <= '0;
         case (r_state)
            S_IDLE: begin
               if (w_found) begin
                  // Fields are captured here so later req changes cannot disturb the transaction
                  r_ptr   <= w_pick;
                  r_addr  <= req_addr[w_pick];
                  r_wdata <= req_wdata[w_pick];
                  r_sel   <= 1'b1;
                  r_we    <= req_we[w_pick];
                  r_oe    <= !req_we[w_pick];
               end
            end
            S_ACCESS: begin
               r_ack <= N_REQ'(1) << r_ptr;
               if (r_oe) r_rdata <= bus_data;
            end
            default: ;
         endcase
      end
   end

   // Write data is driven only while the write strobe is up; reset releases it at once
   assign bus_data    = r_we ? r_wdata : {DATA_N{1'bz}};
   assign ack         = r_ack;
   assign rdata       = r_rdata;
   assign busy        = (r_state != S_IDLE);
   assign periph_sel  = r_sel;
   assign periph_addr = r_addr;
   assign bus_we      = r_we;
   assign bus_oe      = r_oe;

endmodule
